// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 adder/subtractor, generic in exponent/fraction width.
// Round-to-nearest-even, flush-to-zero for subnormals, special-value bypass.
// Pipe: input capture -> align -> add -> normalise/round, all gated by one
// global advance enable so a stalled output freezes every stage in place.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   res,
    output logic [3:0]             flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;   // hidden + fraction + G,R,S
    localparam int SW  = MAN_W + 5;   // MW plus carry
    localparam int EW2 = EXP_W + 2;   // signed exponent working width
    localparam int unsigned SH_MAX = MAN_W + 3;

    localparam logic [EXP_W-1:0]       EXP_ONES = '1;
    localparam logic [W-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW2-1:0]  E_ONE    = EW2'(1);
    localparam logic signed [EW2-1:0]  E_INF    = $signed({2'b00, EXP_ONES});
    localparam logic signed [EW2-1:0]  E_ZERO   = '0;
    localparam logic [EW2-1:0]         LZ_ONE   = EW2'(1);

    logic en;
    logic out_valid_q;
    logic [W-1:0] res_q;
    logic [3:0]   flags_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

    // ---------------- input capture ----------------
    logic         v0_q;
    logic [W-1:0] a_q, b_q;
    logic         sub_q;

    // Register accepted operands; a fresh operation enters on every enabled edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else if (en) begin
            v0_q <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
            end
        end
    end

    // ---------------- stage 1: classify / swap / align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb, fa_f, fb_f;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, a_ge_b;

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1] ^ sub_q;
    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    // Exponent zero covers true zeros and flushed subnormals alike.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign fa_f   = a_zero ? '0 : fa;
    assign fb_f   = b_zero ? '0 : fb;
    assign a_ge_b = {ea, fa_f} >= {eb, fb_f};

    logic             spc1_d, inv1_d, sign1_d, esub1_d, stk1;
    logic [W-1:0]     spc_res1_d;
    logic [EXP_W-1:0] exp1_d, es1, d1;
    logic [MW-1:0]    ml1_d, ms_raw, ms_sh, ms1_d;
    int unsigned      sh1;

    // Special-value tagging plus swap and sticky-preserving alignment shift.
    always_comb begin
        spc1_d     = 1'b0;
        spc_res1_d = '0;
        inv1_d     = 1'b0;
        esub1_d    = sa ^ sb;
        sign1_d    = 1'b0;
        exp1_d     = '0;
        es1        = '0;
        ml1_d      = '0;
        ms_raw     = '0;
        d1         = '0;
        sh1        = 0;
        ms_sh      = '0;
        stk1       = 1'b0;
        ms1_d      = '0;

        if (a_nan || b_nan) begin
            spc1_d     = 1'b1;
            spc_res1_d = QNAN;
            inv1_d     = a_snan || b_snan;
        end else if (a_inf && b_inf) begin
            spc1_d = 1'b1;
            if (sa != sb) begin
                spc_res1_d = QNAN;
                inv1_d     = 1'b1;
            end else begin
                spc_res1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            spc1_d     = 1'b1;
            spc_res1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spc1_d     = 1'b1;
            spc_res1_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end

        if (a_ge_b) begin
            sign1_d = sa;
            exp1_d  = ea;
            ml1_d   = {!a_zero, fa_f, 3'b000};
            es1     = eb;
            ms_raw  = {!b_zero, fb_f, 3'b000};
        end else begin
            sign1_d = sb;
            exp1_d  = eb;
            ml1_d   = {!b_zero, fb_f, 3'b000};
            es1     = ea;
            ms_raw  = {!a_zero, fa_f, 3'b000};
        end

        d1  = exp1_d - es1;
        sh1 = 32'(d1);
        if (sh1 > SH_MAX) sh1 = SH_MAX;
        ms_sh = ms_raw >> sh1;
        for (int unsigned i = 0; i < MW; i++) begin
            if (i < sh1) stk1 = stk1 | ms_raw[i];
        end
        ms1_d = {ms_sh[MW-1:1], ms_sh[0] | stk1};
    end

    logic             v1_q, spc1_q, inv1_q, sign1_q, esub1_q;
    logic [W-1:0]     spc_res1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [MW-1:0]    ml1_q, ms1_q;

    // Align stage register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            spc1_q     <= 1'b0;
            inv1_q     <= 1'b0;
            sign1_q    <= 1'b0;
            esub1_q    <= 1'b0;
            spc_res1_q <= '0;
            exp1_q     <= '0;
            ml1_q      <= '0;
            ms1_q      <= '0;
        end else if (en) begin
            v1_q       <= v0_q;
            spc1_q     <= spc1_d;
            inv1_q     <= inv1_d;
            sign1_q    <= sign1_d;
            esub1_q    <= esub1_d;
            spc_res1_q <= spc_res1_d;
            exp1_q     <= exp1_d;
            ml1_q      <= ml1_d;
            ms1_q      <= ms1_d;
        end
    end

    // ---------------- stage 2: magnitude add/subtract ----------------
    logic [SW-1:0] sum2_d;
    assign sum2_d = esub1_q ? ({1'b0, ml1_q} - {1'b0, ms1_q})
                            : ({1'b0, ml1_q} + {1'b0, ms1_q});

    logic             v2_q, spc2_q, inv2_q, sign2_q, esub2_q;
    logic [W-1:0]     spc_res2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [SW-1:0]    sum2_q;

    // Add stage register; the swap guarantees a non-negative magnitude.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q       <= 1'b0;
            spc2_q     <= 1'b0;
            inv2_q     <= 1'b0;
            sign2_q    <= 1'b0;
            esub2_q    <= 1'b0;
            spc_res2_q <= '0;
            exp2_q     <= '0;
            sum2_q     <= '0;
        end else if (en) begin
            v2_q       <= v1_q;
            spc2_q     <= spc1_q;
            inv2_q     <= inv1_q;
            sign2_q    <= sign1_q;
            esub2_q    <= esub1_q;
            spc_res2_q <= spc_res1_q;
            exp2_q     <= exp1_q;
            sum2_q     <= sum2_d;
        end
    end

    // ---------------- stage 3: normalise / round / pack ----------------
    logic signed [EW2-1:0] e_n;
    logic [EW2-1:0]        lzc;
    logic                  found, g, r, st, inc;
    logic [MW-1:0]         norm;
    logic [MAN_W:0]        frac_inc;
    logic [W-1:0]          res_d;
    logic [3:0]            flags_d;

    // Normalise, round to nearest even, then resolve overflow/underflow.
    always_comb begin
        res_d    = '0;
        flags_d  = '0;
        e_n      = $signed({2'b00, exp2_q});
        lzc      = '0;
        found    = 1'b0;
        norm     = '0;
        g        = 1'b0;
        r        = 1'b0;
        st       = 1'b0;
        inc      = 1'b0;
        frac_inc = '0;

        if (spc2_q) begin
            res_d   = spc_res2_q;
            flags_d = {inv2_q, 3'b000};
        end else begin
            if (sum2_q[SW-1]) begin
                norm = {sum2_q[SW-1:2], sum2_q[1] | sum2_q[0]};
                e_n  = e_n + E_ONE;
            end else begin
                for (int i = MW - 1; i >= 0; i--) begin
                    if (!found) begin
                        if (sum2_q[i]) found = 1'b1;
                        else           lzc   = lzc + LZ_ONE;
                    end
                end
                norm = sum2_q[MW-1:0] << lzc;
                e_n  = e_n - $signed(lzc);
            end

            g   = norm[2];
            r   = norm[1];
            st  = norm[0];
            inc = g & (r | st | norm[3]);
            // A carry out of the fraction means 1.11..1 rounded up to 10.0.
            frac_inc = {1'b0, norm[MW-2:3]} + {{MAN_W{1'b0}}, inc};
            if (frac_inc[MAN_W]) e_n = e_n + E_ONE;

            // Hidden bit clear after normalising means the sum was exactly zero.
            if (!norm[MW-1]) begin
                res_d = {esub2_q ? 1'b0 : sign2_q, {(W-1){1'b0}}};
            end else if (e_n >= E_INF) begin
                res_d   = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
                flags_d = 4'b0101;
            end else if (e_n <= E_ZERO) begin
                res_d   = {sign2_q, {(W-1){1'b0}}};
                flags_d = 4'b0011;
            end else begin
                res_d   = {sign2_q, e_n[EXP_W-1:0], frac_inc[MAN_W-1:0]};
                flags_d = {3'b000, g | r | st};
            end
        end
    end

    // Output register; result and flags only change when a valid op lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (single precision): directed vectors,
// latency, output back-pressure and mid-flight reset.
module tb_fp_addsub_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [3:0]  flags;

    logic [31:0] cur_r;
    logic [3:0]  cur_f;
    logic [35:0] exp_q[$];
    vec_t        vt[17];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n0;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'(res), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res", 64'(res), 64'(e[35:4]));
                    check_eq("flags", 64'(flags), 64'(e[3:0]));
                    n_out++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back({cur_r, cur_f});
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input vec_t v);
        bit taken;
        taken    = 1'b0;
        a        = v.a;
        b        = v.b;
        sub      = v.sub;
        cur_r    = v.r;
        cur_f    = v.f;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        check_eq("send_taken", 64'(taken), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = {32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        vt[1]  = {32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vt[2]  = {32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vt[3]  = {32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vt[4]  = {32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vt[5]  = {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vt[6]  = {32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vt[7]  = {32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vt[8]  = {32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vt[9]  = {32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000};
        vt[10] = {32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
        vt[11] = {32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vt[12] = {32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
        vt[13] = {32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
        vt[14] = {32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vt[15] = {32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vt[16] = {32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        cur_r     = '0;
        cur_f     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_res", 64'(res), 64'd0);
        check_eq("rst_flags", 64'(flags), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op latency.
        send(vt[0]);
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("lat_valid", 64'(out_valid), 64'(k == 3));
        end
        drain();

        // Directed vectors, back to back.
        for (int i = 0; i < 17; i++) send(vt[i]);
        in_valid = 1'b0;
        drain();

        // Output stall of 4 cycles starting when out_valid first rises.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vt[i]);
                in_valid = 1'b0;
            end
            begin
                bit          seen;
                logic [31:0] hold_exp;
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                check_eq("stall_seen", 64'(seen), 64'd1);
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    hold_exp = (exp_q.size() != 0) ? exp_q[0][35:4] : 32'hxxxxxxxx;
                    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
                    check_eq("stall_valid", 64'(out_valid), 64'd1);
                    check_eq("stall_hold", 64'(res), 64'(hold_exp));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("stall_delivered", 64'(n_out - n0), 64'd6);

        // Reset with three operations in flight.
        for (int i = 10; i < 13; i++) send(vt[i]);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_res", 64'(res), 64'd0);
        check_eq("mrst_flags", 64'(flags), 64'd0);
        check_eq("mrst_in_ready", 64'(in_ready), 64'd1);
        n0 = n_out;
        repeat (8) @(posedge clk);
        #1;
        check_eq("mrst_no_stale", 64'(n_out - n0), 64'd0);
        send(vt[15]);
        in_valid = 1'b0;
        drain();
        check_eq("mrst_next_op", 64'(n_out - n0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
